// File: rtl/sync_fifo_controller.sv
// sync_fifo_controller: pointer/flag controller for a synchronous FIFO whose
// storage lives in an external dual-port memory with a registered read port.
// Pointers carry one extra wrap bit so full and empty can be told apart.
// Optional error flags are built when SYNC_FIFO_ERROR_FLAGS_EN is defined.
//
// Handshake: a push is accepted (write_enable) whenever push is high and the
// FIFO is not full; a pop is accepted (read_enable) whenever pop is high and
// the FIFO is not empty. Both strobes are combinational from current state.
// The memory registers its read data, so read_valid follows read_enable by
// exactly one cycle. Requests are ignored while reset is high.
module sync_fifo_controller #(
   parameter int  NUM_ADDRESS       = 8,
   parameter int  ALMOST_FULL_LEVEL = NUM_ADDRESS - 2,
   localparam int AW                = $clog2(NUM_ADDRESS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   output logic          write_enable,
   output logic          read_enable,
   output logic [AW-1:0] write_address,
   output logic [AW-1:0] read_address,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic [AW:0]   count,
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
   input  logic          err_clear,
   output logic          overflow_err,
   output logic          underflow_err,
`endif
   output logic          read_valid
);

   localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
   localparam logic [AW:0] AF_LEVEL = (AW+1)'(ALMOST_FULL_LEVEL);

   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        r_read_valid;
   logic        w_full;
   logic        w_empty;
   logic        w_push_acc;
   logic        w_pop_acc;
   logic [AW:0] w_count;

   // Status flags and accept strobes derived from the current pointers.
   always_comb begin
      w_empty    = (r_wr_ptr == r_rd_ptr);
      w_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
      w_count    = r_wr_ptr - r_rd_ptr;
      w_push_acc = push && !w_full  && !reset;
      w_pop_acc  = pop  && !w_empty && !reset;
   end

   // Pointer advance on accepted requests; wraps modulo 2*NUM_ADDRESS.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   // read_valid tracks the memory read register one cycle after read_enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_read_valid <= 1'b0;
      else       r_read_valid <= w_pop_acc;
   end

`ifdef SYNC_FIFO_ERROR_FLAGS_EN
   logic r_overflow_err;
   logic r_underflow_err;

   // Sticky misuse flags; a new error wins over a same-cycle clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overflow_err  <= 1'b0;
         r_underflow_err <= 1'b0;
      end else begin
         if (push && w_full)      r_overflow_err  <= 1'b1;
         else if (err_clear)      r_overflow_err  <= 1'b0;
         if (pop && w_empty)      r_underflow_err <= 1'b1;
         else if (err_clear)      r_underflow_err <= 1'b0;
      end
   end

   assign overflow_err  = r_overflow_err;
   assign underflow_err = r_underflow_err;
`endif

   assign write_enable  = w_push_acc;
   assign read_enable   = w_pop_acc;
   assign write_address = r_wr_ptr[AW-1:0];
   assign read_address  = r_rd_ptr[AW-1:0];
   assign full          = w_full;
   assign empty         = w_empty;
   assign almost_full   = (w_count >= AF_LEVEL);
   assign count         = w_count;
   assign read_valid    = r_read_valid;

endmodule

// File: doc/sync_fifo_controller.md
SYNC_FIFO_CONTROLLER -- requirements
Module: sync_fifo_controller

Interface
REQ-001 SHALL have parameter NUM_ADDRESS, default 8: FIFO depth, power of two, >= 2.
REQ-002 SHALL have parameter ALMOST_FULL_LEVEL, default NUM_ADDRESS-2: count threshold for almost_full, range 1..NUM_ADDRESS.
REQ-003 SHALL use AW = $clog2(NUM_ADDRESS) for address width and AW+1 for count width.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 push  input  1  write request.
REQ-007 pop  input  1  read request.
REQ-008 write_enable  output  1  memory write strobe (accepted push).
REQ-009 read_enable  output  1  memory read-register strobe (accepted pop).
REQ-010 write_address  output  AW  memory write address.
REQ-011 read_address  output  AW  memory read address.
REQ-012 full, empty, almost_full  output  1 each  status flags.
REQ-013 count  output  AW+1  current occupancy, 0..NUM_ADDRESS.
REQ-014 read_valid  output  1  memory read_data_out is valid this cycle.

Function
REQ-015 Push accept SHALL be push && !full; pop accept SHALL be pop && !empty; both SHALL be combinational from current state.
REQ-016 write_enable SHALL equal push accept; read_enable SHALL equal pop accept (same cycle, no register).
REQ-017 Write and read pointers SHALL each be AW+1 bits; write_address/read_address SHALL be their low AW bits.
REQ-018 Each accepted push/pop SHALL increment its pointer by 1 at the next edge, wrapping modulo 2*NUM_ADDRESS.
REQ-019 empty SHALL be 1 when pointers are equal; full SHALL be 1 when low AW bits match and MSBs differ.
REQ-020 count SHALL equal write pointer minus read pointer modulo 2*NUM_ADDRESS.
REQ-021 almost_full SHALL be 1 when count >= ALMOST_FULL_LEVEL.
REQ-022 Simultaneous accepted push and pop SHALL advance both pointers with count unchanged.
REQ-023 Push and pop when full: pop accepted, push rejected; count falls by 1.
REQ-024 Push and pop when empty: push accepted, pop rejected; count rises by 1.
REQ-025 Rejected requests SHALL cause no pointer change and no strobe.
REQ-026 read_valid SHALL be a register set to read_enable each cycle (1-cycle latency, matching the memory read register).
REQ-027 Address wrap from NUM_ADDRESS-1 to 0 SHALL be seamless, with no lost or duplicated entry.

Reset
REQ-028 Asserting reset SHALL immediately clear both pointers, read_valid and error flags, regardless of clk.
REQ-029 During and after reset: empty=1, full=0, almost_full=0, count=0, addresses=0, read_valid=0.
REQ-030 Reset mid-operation SHALL discard all contents; push/pop are ignored while reset is high.

Configuration
REQ-031 Macro SYNC_FIFO_ERROR_FLAGS_EN, when defined, SHALL add outputs overflow_err and underflow_err (1 bit each) and input err_clear (1 bit).
REQ-032 With the macro, overflow_err SHALL set on push while full and underflow_err on pop while empty; both sticky until err_clear or reset; set takes priority over err_clear in the same cycle.
REQ-033 Without the macro, those ports and their logic SHALL be absent; all other behaviour identical.

Verification
REQ-034 Reset, then 8 pushes (NUM_ADDRESS=8) -> write_address 0..7, full=1 after 8th, count=8, almost_full=1 from count=6.
REQ-035 From full, push+pop together -> write_enable=0, read_enable=1, count=7, full=0.
REQ-036 From empty, push+pop together -> write_enable=1, read_enable=0, count=1, read_valid=0 next cycle.
REQ-037 20 push/pop pairs with 3 items preloaded -> addresses wrap 7->0, count constant 3, read_valid 1 cycle after each read_enable, data order preserved.
REQ-038 Assert reset asynchronously mid-burst at count=5 -> count=0, empty=1 before the next clk edge.
REQ-039 With SYNC_FIFO_ERROR_FLAGS_EN: pop when empty -> underflow_err=1 next cycle and held; err_clear pulse -> 0; push when full -> overflow_err=1.
